// File: rtl/bus_dma_pkg.sv
// -----------------------------------------------------------------------------
// bus_dma_pkg
// Shared constants for the bus-master copy engine: bus widths, the default
// word-count width and the 3-bit FSM state encoding.
// -----------------------------------------------------------------------------
package bus_dma_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int LEN_W_DEF = 8;

  // FSM state encoding (plain constants so legacy tools can consume it)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/bus_dma_ctrl_addr_cnt.sv
// -----------------------------------------------------------------------------
// dma_addr_cnt
// Loadable incrementing word-address register. Used twice by bus_dma_ctrl,
// once for the source pointer and once for the destination pointer.
// Increments wrap modulo 2**ADDR_W.
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low clear
//   load_i     - load load_val_i (has priority over inc_i)
//   load_val_i - value to load
//   inc_i      - advance the address by one word
//   cnt_o      - current address
// -----------------------------------------------------------------------------
module dma_addr_cnt
  import bus_dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next address: load wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Address register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_dma_ctrl.sv
// -----------------------------------------------------------------------------
// bus_dma_ctrl
// Bus-master copy engine. On an accepted start pulse it copies `length`
// 32-bit words from src_addr.. to dst_addr.. one word at a time: request the
// bus, read a word, wait RD_LAT cycles for the data, write it, repeat.
// Losing the grant mid-word discards that word and retries it after a new
// request. All outputs are registered.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   start              - launch pulse, accepted only in IDLE
//   src_addr, dst_addr - first source / destination word address
//   length             - number of words (0 completes with no bus activity)
//   M_req, M_wr        - bus request and write strobe (0 = read)
//   M_address, M_dout  - bus address and write data
//   M_grant, M_din     - arbiter grant and read data
//   busy, done         - transfer in progress, one-cycle completion pulse
// -----------------------------------------------------------------------------
module bus_dma_ctrl
  import bus_dma_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din,
  output logic              busy,
  output logic              done
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              load_s;
  logic              adv_s;
  logic [ADDR_W-1:0] src_s;
  logic [ADDR_W-1:0] dst_s;

  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  dma_addr_cnt u_src_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load_s),
    .load_val_i (src_addr),
    .inc_i      (adv_s),
    .cnt_o      (src_s)
  );

  dma_addr_cnt u_dst_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load_s),
    .load_val_i (dst_addr),
    .inc_i      (adv_s),
    .cnt_o      (dst_s)
  );

  // FSM next state, word counter, read-latency counter and data capture.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    wait_d  = wait_q;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            load_s  = 1'b1;
            count_d = length;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (M_grant) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RD: begin
        if (!M_grant) begin
          state_d = ST_REQ;
        end else begin
          wait_d  = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!M_grant) begin
          state_d = ST_REQ;
        end else if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          data_d  = M_din;
          state_d = ST_WR;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      ST_WR: begin
        // Pointers and count only advance once the write has actually gone
        // out under grant; a lost grant retries the same word.
        if (!M_grant) begin
          state_d = ST_REQ;
        end else begin
          adv_s   = 1'b1;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the state being entered, so they register
  // alongside it.
  always_comb begin
    req_d  = 1'b0;
    wr_d   = 1'b0;
    addr_d = addr_q;
    dout_d = dout_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_REQ, ST_RD_WAIT: begin
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_RD: begin
        req_d  = 1'b1;
        busy_d = 1'b1;
        // Coming from WR the source pointer bumps on this same edge.
        if (state_q == ST_WR) begin
          addr_d = src_s + ADDR_W'(1);
        end else begin
          addr_d = src_s;
        end
      end
      ST_WR: begin
        req_d  = 1'b1;
        busy_d = 1'b1;
        wr_d   = 1'b1;
        addr_d = dst_s;
        dout_d = data_d;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered bus/host outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      data_q  <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign M_req     = req_q;
  assign M_wr      = wr_q;
  assign M_address = addr_q;
  assign M_dout    = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bus_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_dma_ctrl
// Scoreboard bench: directed transfers push the expected bus writes and the
// expected done pulse (cycle and prior busy) into queues; a monitor pops and
// compares whenever the DUT performs a granted write or pulses done.
// -----------------------------------------------------------------------------
module tb_bus_dma_ctrl;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int   cyc;   // -1: cycle not checked
    logic pb;    // busy expected in the cycle before done
  } dn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = 8'h00;
  logic [7:0]  dst_addr = 8'h00;
  logic [7:0]  length = 8'h00;
  logic        M_req, M_wr, M_grant, busy, done;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din;

  logic        gnt_en = 1'b1;
  logic [31:0] mem [0:255];
  logic [31:0] rdata = 32'h0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_busy = 1'b0;

  wr_t wq[$];
  dn_t dq[$];

  bus_dma_ctrl #(.LEN_W(8), .RD_LAT(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .M_req     (M_req),
    .M_wr      (M_wr),
    .M_address (M_address),
    .M_dout    (M_dout),
    .M_grant   (M_grant),
    .M_din     (M_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter and slave memory: grant follows request; read data is registered.
  assign M_grant = gnt_en & M_req;
  assign M_din   = rdata;

  always @(posedge clk) begin
    if (M_req && M_grant && M_wr) mem[M_address] <= M_dout;
    rdata <= mem[M_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every granted write and every done pulse to the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (M_wr && M_grant) begin
          if (wq.size() == 0) begin
            chk("unexpected_write_addr", {24'h0, M_address}, 32'hFFFFFFFF);
          end else begin
            wr_t e;
            e = wq.pop_front();
            chk("write_addr", {24'h0, M_address}, {24'h0, e.a});
            chk("write_data", M_dout, e.d);
          end
        end
        if (done) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 32'h1, 32'h0);
          end else begin
            dn_t e;
            e = dq.pop_front();
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", {31'h0, busy}, 32'h0);
            chk("busy_before_done", {31'h0, prev_busy}, {31'h0, e.pb});
          end
        end
        prev_busy = busy;
      end
    end
  end

  // Launch a transfer; k is the index of the DONE cycle counted from the
  // start edge (cycle 1 is the one right after it), -1 to skip that check.
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input int k, input logic pb, input bit push_done);
    @(negedge clk);
    if (push_done) begin
      dn_t e;
      e.cyc = (k < 0) ? -1 : cyc + k;
      e.pb  = pb;
      dq.push_back(e);
    end
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  // Bounded wait until every expected event has been consumed.
  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, wq.size() + dq.size(), 32'h0);
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    bit   seen;
    int   n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h00] = 32'h11111111;
    mem[8'h01] = 32'h22222222;
    mem[8'h02] = 32'h33333333;
    mem[8'h03] = 32'h44444444;
    mem[8'hFE] = 32'hCAFE00FE;
    mem[8'hFF] = 32'hCAFE00FF;
    mem[8'h80] = 32'h0BAD0001;
    mem[8'h81] = 32'h0BAD0002;
    mem[8'h82] = 32'h0BAD0003;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {M_req, M_wr, busy, done, M_address, 20'h0},
        32'h0);
    chk("rst_dout", M_dout, 32'h0);

    // Single word, immediate grant: DONE is the 5th cycle after start
    push_wr(8'h40, 32'hDEADBEEF);
    launch(8'h10, 8'h40, 8'd1, 5, 1'b1, 1'b1);
    drain("t1_drain", 40);
    chk("t1_mem40", mem[8'h40], 32'hDEADBEEF);

    // Four words, grant held off for 3 REQ cycles
    gnt_en = 1'b0;
    push_wr(8'hC0, 32'h11111111);
    push_wr(8'hC1, 32'h22222222);
    push_wr(8'hC2, 32'h33333333);
    push_wr(8'hC3, 32'h44444444);
    launch(8'h00, 8'hC0, 8'd4, 17, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_stall_req", {31'h0, M_req}, 32'h1);
    end
    @(negedge clk);
    gnt_en = 1'b1;
    drain("t2_drain", 60);
    chk("t2_memC3", mem[8'hC3], 32'h44444444);

    // Wrap-around plus a start pulse mid-transfer that must be ignored
    push_wr(8'h20, 32'hCAFE00FE);
    push_wr(8'h21, 32'hCAFE00FF);
    push_wr(8'h22, 32'h11111111);
    launch(8'hFE, 8'h20, 8'd3, 11, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    src_addr = 8'h55;
    dst_addr = 8'h66;
    length   = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t3_drain", 60);
    chk("t3_mem22", mem[8'h22], 32'h11111111);
    chk("t3_mem66", mem[8'h66], 32'h0);

    // Zero length: done next cycle, no request
    launch(8'h10, 8'h50, 8'd0, 1, 1'b0, 1'b1);
    seen = M_req;
    repeat (3) begin
      @(negedge clk);
      seen = seen | M_req;
    end
    chk("t4_no_req", {31'h0, seen}, 32'h0);
    drain("t4_drain", 10);

    // Grant lost during WR of word 2 of 3: word 2 is retried
    push_wr(8'h90, 32'h0BAD0001);
    push_wr(8'h91, 32'h0BAD0002);
    push_wr(8'h92, 32'h0BAD0003);
    launch(8'h80, 8'h90, 8'd3, 15, 1'b1, 1'b1);
    n = 0;
    while (!(M_req && !M_wr && M_address == 8'h81) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rd81_seen", {31'h0, (n < 30)}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1 gnt_en = 1'b0;
    @(negedge clk);
    chk("t5_wr_nogrant", {31'h0, M_wr}, 32'h1);
    @(negedge clk);
    chk("t5_wr_dropped", {31'h0, M_wr}, 32'h0);
    chk("t5_req_again", {31'h0, M_req}, 32'h1);
    gnt_en = 1'b1;
    drain("t5_drain", 60);
    chk("t5_mem91", mem[8'h91], 32'h0BAD0002);
    chk("t5_mem92", mem[8'h92], 32'h0BAD0003);

    // Asynchronous reset in the middle of RD_WAIT: no done, no write
    launch(8'h80, 8'hA0, 8'd2, -1, 1'b1, 1'b0);
    n = 0;
    while (!(M_req && !M_wr && M_address == 8'h80) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6_rd80_seen", {31'h0, (n < 30)}, 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_ctl", {28'h0, M_req, M_wr, busy, done}, 32'h0);
    chk("t6_async_addr", {24'h0, M_address}, 32'h0);
    chk("t6_async_dout", M_dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle", {29'h0, M_req, busy, done}, 32'h0);
    chk("t6_memA0", mem[8'hA0], 32'h0);
    chk("t6_queues", wq.size() + dq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends with a summary line.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_dma_ctrl.md
Name: bus_dma_ctrl

Overview:
Bus-master copy engine that moves a block of 32-bit words from one slave address range to another over the shared two-master bus. It connects to one master port (req/wr/address/dout in, grant/din back) and sequences read-then-write transactions word by word. A host launches it with a start pulse. It releases the bus when the block is complete.

Parameters:
LEN_W, 8, width of the word-count input and internal counter
RD_LAT, 1, cycles from read address presentation to valid M_din (the bus registers the slave select)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle launch pulse; ignored while busy
src_addr  in  8  first source word address, sampled on accepted start
dst_addr  in  8  first destination word address, sampled on accepted start
length  in  LEN_W  number of words to copy, sampled on accepted start
M_req  out  1  bus request to arbiter
M_wr  out  1  1 = write, 0 = read
M_address  out  8  bus address
M_dout  out  32  write data to bus
M_grant  in  1  arbiter grant for this master
M_din  in  32  read data from bus
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (async, reset_n=0): state IDLE; M_req=0, M_wr=0, M_address=0, M_dout=0, busy=0, done=0; internal src/dst/count/data registers cleared. Abort is immediate, with no completion pulse.
- All outputs are registered.
- States: IDLE, REQ, RD, RD_WAIT, WR, DONE.
- IDLE:
  - start=1 with length!=0: load src, dst and count; set busy=1; go to REQ.
  - start=1 with length==0: go to DONE; no bus activity.
- REQ: M_req=1, M_wr=0. Stay until M_grant=1, then go to RD.
- RD: drive M_address=src, M_wr=0 for one cycle, then go to RD_WAIT.
- RD_WAIT: wait RD_LAT cycles, then capture M_din into the data register and go to WR.
- WR:
  - Drive M_address=dst, M_wr=1, M_dout=data for one cycle.
  - Then src+1, dst+1, count-1.
  - If the new count is 0, go to DONE; otherwise go to RD.
- M_req stays 1 from REQ through the final WR cycle. It drops in the DONE cycle.
- Grant loss: if M_grant=0 in any of RD, RD_WAIT or WR, discard the in-flight word and go to REQ. Src, dst and count keep their pre-word values, so the same word is retried.
- DONE: done=1 for exactly one cycle, busy=0, M_req=0, M_wr=0; return to IDLE.
- Addresses wrap modulo 256 (8'hFF+1 = 8'h00). Overlapping ranges are copied in ascending order, with no hazard protection.
- start while busy: ignored, with no effect on registers.
- start in the DONE cycle: ignored; only accepted in IDLE.
- Throughput, steady grant: 3 cycles per word (RD, RD_WAIT, WR) plus 1 REQ cycle per block.

Decomposition:
- Shared package bus_dma_pkg:
  - state encoding constants (3-bit)
  - ADDR_W=8, DATA_W=32
  - LEN_W default
- One natural sub-module, dma_addr_cnt: 8-bit loadable incrementing register with async active-low clear. Instanced twice, for src and dst.
- The count decrement and the FSM stay in the top module.

Test Plan:
- Single word, grant immediate: src=8'h10, dst=8'h40, length=1, slave word 0x10 holds 32'hDEADBEEF.
  - Required: one read at 8'h10, then a write at 8'h40 with M_dout=32'hDEADBEEF.
  - done pulses 5 cycles after start; the DONE cycle is the 5th cycle after the start edge.
  - Finally, slave word 0x40 reads DEADBEEF.
- Four-word block with grant held off 3 cycles: src=8'h00, dst=8'hC0, length=4.
  - Required: M_req high for 3 stalled REQ cycles.
  - Then addresses 00,C0,01,C1,02,C2,03,C3 in order; data copied exactly; busy falls together with the done pulse.
- Wrap-around: src=8'hFE, dst=8'h20, length=3.
  - Required: reads at FE, FF, 00; writes at 20, 21, 22.
- length=0 and busy-start: start with length=0.
  - Required: done next cycle, M_req never asserted.
  - Second case: start pulsed mid-transfer must not alter addresses or count.
- Grant loss and reset:
  - Drop M_grant during WR of word 2 of a 3-word copy. Required: M_wr returns 0, REQ re-entered, word 2 re-read and rewritten, final memory correct.
  - Then assert reset_n=0 mid-RD_WAIT. Required: all outputs 0 asynchronously, no done pulse, IDLE after release.
